iterative_muldiv: RTL

- Multi-cycle 64-bit multiply/divide unit sitting between operand read and writeback.
- Consumes BusA/BusB as read from the 32x64 register file and returns a result on BusW/RW/RegWr for the file's negedge write port.
- Radix-2 iterative datapath, one operation in flight.
- Supports MUL, UMULH, UDIV, SDIV with LEGv8 semantics.

---
 rtl/iterative_muldiv_pkg.sv | 27 ++
 rtl/muldiv_step.sv | 40 ++++
 rtl/iterative_muldiv.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/iterative_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op and state
// encodings plus default widths.
package iterative_muldiv_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_IDX_W = 5;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_UMULH = 2'b01,
        OP_UDIV  = 2'b10,
        OP_SDIV  = 2'b11
    } opE;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } stateE;

    // Both divide encodings share the upper op bit.
    function automatic logic isDivOp(input opE op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational radix-2 step: unsigned shift-add for multiply, restoring
// shift-subtract for divide, over a {hi, lo} double-width working register.
module muldiv_step
    import iterative_muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             isDiv,
    input  logic [WIDTH-1:0] partHi,
    input  logic [WIDTH-1:0] partLo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] nextHi,
    output logic [WIDTH-1:0] nextLo,
    output logic             qBit
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] cand_s;
    logic [WIDTH:0] diff_s;
    logic           geq_s;

    // Compute both step flavours and select by mode.
    always_comb begin
        sum_s  = {1'b0, partHi} + (partLo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        cand_s = {partHi, partLo[WIDTH-1]};
        diff_s = cand_s - {1'b0, operand};
        geq_s  = (cand_s >= {1'b0, operand});
        if (isDiv) begin
            // Remainder stays below the divisor, so the difference fits WIDTH bits.
            nextHi = geq_s ? diff_s[WIDTH-1:0] : cand_s[WIDTH-1:0];
            nextLo = {partLo[WIDTH-2:0], 1'b0};
            qBit   = geq_s;
        end else begin
            nextHi = sum_s[WIDTH:1];
            nextLo = {sum_s[0], partLo[WIDTH-1:1]};
            qBit   = 1'b0;
        end
    end

endmodule

// File: rtl/iterative_muldiv.sv
// Multi-cycle MUL/UMULH/UDIV/SDIV unit with register-file writeback outputs.
// One operation in flight; WIDTH radix-2 iterations per non-trivial op.
module iterative_muldiv
    import iterative_muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic             Clk,
    input  logic             ResetL,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] BusA,
    input  logic [WIDTH-1:0] BusB,
    input  logic [IDX_W-1:0] RdIn,
    input  logic             Kill,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] BusW,
    output logic [IDX_W-1:0] RW,
    output logic             RegWr
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    stateE            state_r;
    stateE            nextState_s;
    opE               op_r;
    opE               opIn_s;
    logic [IDX_W-1:0] rd_r;
    logic [WIDTH-1:0] operand_r;
    logic [WIDTH-1:0] partHi_r;
    logic [WIDTH-1:0] partLo_r;
    logic [CNT_W-1:0] cnt_r;
    logic             negate_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] busW_r;
    logic [IDX_W-1:0] rw_r;

    logic [WIDTH-1:0] stepHi_s;
    logic [WIDTH-1:0] stepLo_s;
    logic             qBit_s;
    logic [WIDTH-1:0] result_s;
    logic             divZero_s;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic signedOp);
        if (signedOp && v[WIDTH-1]) begin
            return {WIDTH{1'b0}} - v;
        end else begin
            return v;
        end
    endfunction

    assign opIn_s    = opE'(Op);
    assign divZero_s = isDivOp(opIn_s) && (BusB == {WIDTH{1'b0}});

    muldiv_step #(.WIDTH(WIDTH)) uStep (
        .isDiv  (isDivOp(op_r)),
        .partHi (partHi_r),
        .partLo (partLo_r),
        .operand(operand_r),
        .nextHi (stepHi_s),
        .nextLo (stepLo_s),
        .qBit   (qBit_s)
    );

    // Next-state logic; Kill only aborts CALC/FIX, Start only counts in IDLE.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (Start) begin
                    nextState_s = divZero_s ? S_DONE : S_CALC;
                end else begin
                    nextState_s = S_IDLE;
                end
            end
            S_CALC: begin
                if (Kill) begin
                    nextState_s = S_IDLE;
                end else if (cnt_r == {CNT_W{1'b0}}) begin
                    nextState_s = S_FIX;
                end else begin
                    nextState_s = S_CALC;
                end
            end
            S_FIX: begin
                if (Kill) begin
                    nextState_s = S_IDLE;
                end else begin
                    nextState_s = S_DONE;
                end
            end
            S_DONE:  nextState_s = S_IDLE;
            default: nextState_s = S_IDLE;
        endcase
    end

    // Final result selection from the working register.
    always_comb begin
        result_s = partLo_r;
        case (op_r)
            OP_MUL:   result_s = partLo_r;
            OP_UMULH: result_s = partHi_r;
            OP_UDIV:  result_s = partLo_r;
            OP_SDIV:  result_s = negate_r ? ({WIDTH{1'b0}} - partLo_r) : partLo_r;
            default:  result_s = partLo_r;
        endcase
    end

    // State register and registered handshake outputs.
    always_ff @(posedge Clk or negedge ResetL) begin
        if (!ResetL) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= nextState_s;
            busy_r  <= (nextState_s == S_CALC) || (nextState_s == S_FIX);
            done_r  <= (nextState_s == S_DONE);
        end
    end

    // Operand capture, iteration datapath and writeback registers.
    always_ff @(posedge Clk or negedge ResetL) begin
        if (!ResetL) begin
            op_r      <= OP_MUL;
            rd_r      <= {IDX_W{1'b0}};
            operand_r <= {WIDTH{1'b0}};
            partHi_r  <= {WIDTH{1'b0}};
            partLo_r  <= {WIDTH{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            negate_r  <= 1'b0;
            busW_r    <= {WIDTH{1'b0}};
            rw_r      <= {IDX_W{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (Start) begin
                        op_r     <= opIn_s;
                        rd_r     <= RdIn;
                        cnt_r    <= CNT_LOAD;
                        partHi_r <= {WIDTH{1'b0}};
                        negate_r <= (opIn_s == OP_SDIV) && (BusA[WIDTH-1] ^ BusB[WIDTH-1]);
                        if (isDivOp(opIn_s)) begin
                            operand_r <= magnitude(BusB, opIn_s == OP_SDIV);
                            partLo_r  <= magnitude(BusA, opIn_s == OP_SDIV);
                        end else begin
                            operand_r <= BusA;
                            partLo_r  <= BusB;
                        end
                        if (divZero_s) begin
                            busW_r <= {WIDTH{1'b0}};
                            rw_r   <= RdIn;
                        end
                    end
                end
                S_CALC: begin
                    partHi_r <= stepHi_s;
                    partLo_r <= stepLo_s | {{(WIDTH-1){1'b0}}, qBit_s};
                    cnt_r    <= cnt_r - CNT_ONE;
                end
                S_FIX: begin
                    if (!Kill) begin
                        busW_r <= result_s;
                        rw_r   <= rd_r;
                    end
                end
                S_DONE: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
                default: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign Busy  = busy_r;
    assign Done  = done_r;
    assign RegWr = done_r;
    assign BusW  = busW_r;
    assign RW    = rw_r;

endmodule
